// File: rtl/imem_loader_if.sv
// Host-side load request, word handshake, instruction-memory byte-write port and status
// for the instruction memory loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              load_start;
    logic [ADDR_W-2:0] load_len;
    logic              abort;
    logic              wdata_valid;
    logic [31:0]       wdata;
    logic              wdata_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wbyte;
    logic              fetch_stall;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-2:0] loaded_words;

    modport master (
        output load_start, load_len, abort, wdata_valid, wdata,
        input  wdata_ready, mem_we, mem_waddr, mem_wbyte,
        input  fetch_stall, busy, done, err, loaded_words
    );

    modport slave (
        input  load_start, load_len, abort, wdata_valid, wdata,
        output wdata_ready, mem_we, mem_waddr, mem_wbyte,
        output fetch_stall, busy, done, err, loaded_words
    );
endinterface

// File: rtl/imem_loader.sv
// Loads 32-bit host words into byte-wide instruction memory, little-endian, one byte per cycle,
// while holding the fetch stage stalled for the whole session.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic clk,
    input  logic rst_n,
    imem_loader_if.slave bus
);
    localparam int unsigned LEN_W     = ADDR_W - 1;
    localparam int unsigned MAX_WORDS = ((2 ** ADDR_W) - BASE_ADDR) / 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WR, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  loaded_q, loaded_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       word_q, word_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]        mem_wbyte_q, mem_wbyte_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [1:0]        k_nxt;
    logic [LEN_W-1:0]  idx_nxt;
    logic [ADDR_W-1:0] word_addr;

    assign k_nxt     = k_q + 2'd1;
    assign idx_nxt   = idx_q + LEN_W'(1);
    assign word_addr = ADDR_W'(BASE_ADDR) + ADDR_W'({idx_q, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            loaded_q    <= '0;
            k_q         <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wbyte_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            loaded_q    <= loaded_d;
            k_q         <= k_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wbyte_q <= mem_wbyte_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next state; the write port is registered one byte ahead of the byte counter.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        loaded_d    = loaded_q;
        k_d         = k_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wbyte_d = mem_wbyte_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_start && !bus.abort) begin
                    len_d    = bus.load_len;
                    idx_d    = '0;
                    loaded_d = '0;
                    if (bus.load_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (32'(bus.load_len) > MAX_WORDS) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (bus.wdata_valid) begin
                    word_d      = bus.wdata;
                    k_d         = 2'd0;
                    mem_we_d    = 1'b1;
                    mem_waddr_d = word_addr;
                    mem_wbyte_d = bus.wdata[7:0];
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (k_q != 2'd3) begin
                    k_d         = k_nxt;
                    mem_we_d    = 1'b1;
                    mem_waddr_d = mem_waddr_q + ADDR_W'(1);
                    mem_wbyte_d = word_q[{k_nxt, 3'b000} +: 8];
                end else begin
                    idx_d    = idx_nxt;
                    loaded_d = loaded_q + LEN_W'(1);
                    if (idx_nxt == len_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = bus.abort;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_WAIT);
        busy_d  = (state_d != S_IDLE);
    end

    assign bus.wdata_ready  = ready_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_waddr    = mem_waddr_q;
    assign bus.mem_wbyte    = mem_wbyte_q;
    assign bus.fetch_stall  = busy_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.loaded_words = loaded_q;
endmodule
